// File: rtl/bg_pixel_fifo_pkg.sv
// Shared PPU types: pixel/colour encodings and fetch/FIFO sizing used by the pixel pipeline.
package bg_pixel_fifo_pkg;

   localparam int unsigned FETCH_WIDTH      = 8;
   localparam int unsigned PIXEL_FIFO_DEPTH = 16;

   typedef enum logic [1:0] {
      ColWhite = 2'd0,
      ColLight = 2'd1,
      ColDark  = 2'd2,
      ColBlack = 2'd3
   } gb_color_t;

   typedef struct packed {
      gb_color_t  color;
      logic [2:0] palette;
      logic       bg_prio;
   } ppu_pixel_t;

endpackage

// File: rtl/bg_pixel_fifo.sv
// Background pixel FIFO: 8-pixel tile-row pushes, single-pixel pops, optional SCX fine discard.
// Fine-scroll discard is built only when PPU_FIFO_SCX_DISCARD_EN is defined.
module bg_pixel_fifo
   import bg_pixel_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = PIXEL_FIFO_DEPTH
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             dot_en,
   input  logic                             flush,
   input  logic [2:0]                       scx_fine,
   input  logic                             push_en,
   input  ppu_pixel_t [FETCH_WIDTH-1:0]     push_px,
   output logic                             push_ready,
   input  logic                             pop_en,
   output ppu_pixel_t                       top_px,
   output logic                             empty,
   output logic [$clog2(DEPTH):0]           count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FETCH_CNT = CW'(FETCH_WIDTH);
   localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - FETCH_WIDTH);

   ppu_pixel_t    buffer [DEPTH];
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop, do_advance;
   logic          discard_busy, discard_step;

`ifdef PPU_FIFO_SCX_DISCARD_EN
   logic [2:0] discard_rem_q;

   assign discard_busy = (discard_rem_q != 3'd0);
   assign discard_step = dot_en && discard_busy && (count_q != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         discard_rem_q <= 3'd0;
      end else if (flush) begin
         discard_rem_q <= scx_fine;
      end else if (discard_step) begin
         discard_rem_q <= discard_rem_q - 3'd1;
      end
   end
`else
   logic unused_scx_fine;

   assign unused_scx_fine = ^scx_fine;
   assign discard_busy    = 1'b0;
   assign discard_step    = 1'b0;
`endif

   // Readiness uses the registered count, so a same-cycle pop cannot make room for a push.
   assign push_ready = (count_q <= READY_MAX);
   assign empty      = (count_q == '0) || discard_busy;
   assign do_push    = dot_en && push_en && push_ready;
   assign do_pop     = dot_en && pop_en && !empty;
   assign do_advance = do_pop || discard_step;
   assign top_px     = buffer[rd_ptr_q];
   assign count      = count_q;

   always_comb begin
      count_d = count_q;
      if (do_push) begin
         count_d = count_d + FETCH_CNT;
      end
      if (do_advance) begin
         count_d = count_d - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PW'(FETCH_WIDTH);
         end
         if (do_advance) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q <= count_d;
      end
   end

   // Storage is not reset; pointers and count alone decide what is visible.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            buffer[wr_ptr_q + PW'(i)] <= push_px[i];
         end
      end
   end

endmodule

// File: tb/tb_bg_pixel_fifo.sv
// Directed plus randomized bench for bg_pixel_fifo against a queue-based pixel model.
module tb_bg_pixel_fifo;
   import bg_pixel_fifo_pkg::*;

   localparam int DEPTH = 16;

   logic                         clk;
   logic                         reset;
   logic                         dot_en;
   logic                         flush;
   logic [2:0]                   scx_fine;
   logic                         push_en;
   ppu_pixel_t [FETCH_WIDTH-1:0] push_px;
   logic                         push_ready;
   logic                         pop_en;
   ppu_pixel_t                   top_px;
   logic                         empty;
   logic [$clog2(DEPTH):0]       count;

   bg_pixel_fifo #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .dot_en     (dot_en),
      .flush      (flush),
      .scx_fine   (scx_fine),
      .push_en    (push_en),
      .push_px    (push_px),
      .push_ready (push_ready),
      .pop_en     (pop_en),
      .top_px     (top_px),
      .empty      (empty),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         total = 0;
   int         bad   = 0;
   ppu_pixel_t mq[$];
   int         mdisc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mdisc = 0;
   endtask

   // Applies the current inputs to the model as the next rising edge will.
   task automatic model_step();
      bit m_ready, m_empty;
      if (flush) begin
         mq.delete();
`ifdef PPU_FIFO_SCX_DISCARD_EN
         mdisc = int'(scx_fine);
`else
         mdisc = 0;
`endif
      end else if (dot_en) begin
         m_ready = (mq.size() <= DEPTH - FETCH_WIDTH);
         m_empty = (mq.size() == 0) || (mdisc != 0);
         if (mdisc != 0 && mq.size() != 0) begin
            void'(mq.pop_front());
            mdisc--;
         end else if (pop_en && !m_empty) begin
            void'(mq.pop_front());
         end
         if (push_en && m_ready) begin
            for (int i = 0; i < FETCH_WIDTH; i++) mq.push_back(push_px[i]);
         end
      end
   endtask

   task automatic check_state(input string tag);
      bit m_empty;
      m_empty = (mq.size() == 0) || (mdisc != 0);
      check({tag, ":count"}, 32'(count), 32'(mq.size()));
      check({tag, ":empty"}, 32'(empty), 32'(m_empty));
      check({tag, ":ready"}, 32'(push_ready), 32'(mq.size() <= DEPTH - FETCH_WIDTH));
      if (!m_empty) check({tag, ":top"}, 32'(top_px), 32'(mq[0]));
   endtask

   task automatic cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_state(tag);
   endtask

   task automatic idle();
      dot_en  = 1'b1;
      flush   = 1'b0;
      push_en = 1'b0;
      pop_en  = 1'b0;
   endtask

   // Colours packed two bits per pixel, pixel 0 in the LSBs; palette carries the pixel index.
   task automatic load_colors(input logic [15:0] cols);
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         push_px[i] = '{color: gb_color_t'(cols[2*i +: 2]), palette: 3'(i), bg_prio: 1'b0};
      end
   endtask

   task automatic load_random();
      for (int i = 0; i < FETCH_WIDTH; i++) push_px[i] = ppu_pixel_t'($urandom_range(0, 63));
   endtask

   initial begin
      reset    = 1'b1;
      scx_fine = 3'd0;
      idle();
      load_random();
      model_reset();
      @(posedge clk);
      #1;
      check_state("reset");
      check("reset_empty", 32'(empty), 32'd1);
      check("reset_ready", 32'(push_ready), 32'd1);
      reset = 1'b0;

      // Basic push of 0,1,2,3,0,1,2,3 then drain in order.
      load_colors(16'hE4E4);
      push_en = 1'b1;
      cycle("push1");
      push_en = 1'b0;
      check("basic_count", 32'(count), 32'd8);
      pop_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check("basic_color", 32'(top_px.color), 32'(k % 4));
         cycle("basic_pop");
      end
      pop_en = 1'b0;
      check("basic_empty", 32'(empty), 32'd1);

      // Fill to 16, held push ignored, then pop.
      push_en = 1'b1;
      load_random();
      cycle("fill_a");
      load_random();
      cycle("fill_b");
      check("full_count", 32'(count), 32'd16);
      check("full_ready", 32'(push_ready), 32'd0);
      cycle("held_push");
      push_en = 1'b0;
      pop_en  = 1'b1;
      cycle("pop_from_full");
      check("pop15_ready", 32'(push_ready), 32'd0);
      repeat (6) cycle("drain_to_9");
      check("count9", 32'(count), 32'd9);

      // Push rejected at 9 while pop is taken, then accepted at 8.
      push_en = 1'b1;
      load_random();
      cycle("push_pop_9");
      check("count8", 32'(count), 32'd8);
      pop_en = 1'b0;
      cycle("push_at_8");
      check("count16", 32'(count), 32'd16);
      push_en  = 1'b0;
      flush    = 1'b1;
      scx_fine = 3'd5;
      cycle("flush5");
      flush = 1'b0;

`ifdef PPU_FIFO_SCX_DISCARD_EN
      load_colors(16'h1B1B);
      push_en = 1'b1;
      cycle("disc_push");
      push_en = 1'b0;
      pop_en  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check("disc_empty", 32'(empty), 32'd1);
         cycle("disc_step");
      end
      check("disc_count", 32'(count), 32'd3);
      check("disc_index", 32'(top_px.palette), 32'd5);
      cycle("disc_first_pop");
      pop_en = 1'b0;
`endif

      // Pointer wrap across several push/drain rounds.
      flush    = 1'b1;
      scx_fine = 3'd0;
      cycle("wrap_flush");
      flush = 1'b0;
      repeat (6) begin
         load_random();
         push_en = 1'b1;
         pop_en  = 1'b0;
         cycle("wrap_push");
         push_en = 1'b0;
         pop_en  = 1'b1;
         repeat (8) cycle("wrap_pop");
      end
      pop_en = 1'b0;

      // Flush while a discard is still pending.
      flush    = 1'b1;
      scx_fine = 3'd3;
      cycle("mid_flush_a");
      flush = 1'b0;
      load_random();
      push_en = 1'b1;
      cycle("mid_push");
      push_en = 1'b0;
      cycle("mid_disc");
      flush    = 1'b1;
      scx_fine = 3'd2;
      cycle("mid_flush_b");
      flush = 1'b0;
      check("mid_flush_count", 32'(count), 32'd0);
      load_random();
      push_en = 1'b1;
      cycle("mid_push_b");
      push_en = 1'b0;
      pop_en  = 1'b1;
      repeat (4) cycle("mid_after");

      // dot_en low freezes state.
      load_random();
      pop_en  = 1'b0;
      push_en = 1'b1;
      cycle("frz_push");
      push_en = 1'b0;
      dot_en  = 1'b0;
      pop_en  = 1'b1;
      cycle("frz_pop");
      check("frz_count", 32'(count), 32'(mq.size()));
      idle();

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         dot_en   = ($urandom_range(0, 9) != 0);
         push_en  = $urandom_range(0, 1) == 1;
         pop_en   = $urandom_range(0, 2) != 0;
         flush    = ($urandom_range(0, 39) == 0);
         scx_fine = 3'($urandom_range(0, 7));
         load_random();
         cycle("rand");
      end

      // Asynchronous reset during a push.
      idle();
      push_en = 1'b1;
      load_random();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_state("async_reset");
      @(posedge clk);
      #1;
      check_state("reset_hold");
      reset   = 1'b0;
      push_en = 1'b0;
      cycle("post_reset");
      check("post_reset_empty", 32'(empty), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
